cwm_event_arbiter: RTL and testbench

CWM_EVENT_ARBITER -- requirements
Module: cwm_event_arbiter

---
 rtl/cwm_event_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_cwm_event_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cwm_event_arbiter.sv
// -----------------------------------------------------------------------------
// cwm_event_arbiter
//
// This block collects counter terminal events (cwm_in rising edges) and
// file-card pulses, then offers them one at a time on a valid/ready port.
// After a counter event is accepted, the block drives an active-low clear
// strobe to that counter. It holds the strobe until the counter drops its
// flag or until a timeout expires.
//
// Ports
//   sysclk      single clock, all flops on its rising edge
//   foo_card_n  asynchronous active-low reset
//   cwm_in[4:0] counter terminal flags (Z0, Y1, X2, W3, debct)
//   wdfilecard  one-cycle file-card pulse
//   zz1pb[4:0]  active-low clear strobes, same bit order as cwm_in
//   evt_valid   event offered downstream
//   evt_ready   downstream accepts event
//   evt_id      0-4 counter index, 5 file-card
//   evt_seq     running event sequence number
//   pend[5:0]   pending mask, [5] = file-card counter nonzero
//   evt_ovf     sticky, a file-card pulse was lost at saturation
//   clr_err     sticky, a clear strobe timed out
// -----------------------------------------------------------------------------
module cwm_event_arbiter #(
   parameter int SEQ_W      = 8,
   parameter int CLR_TMO    = 15,
   parameter int FC_DEPTH_W = 4
) (
   input  logic             sysclk,
   input  logic             foo_card_n,
   input  logic [4:0]       cwm_in,
   input  logic             wdfilecard,
   output logic [4:0]       zz1pb,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [2:0]       evt_id,
   output logic [SEQ_W-1:0] evt_seq,
   output logic [5:0]       pend,
   output logic             evt_ovf,
   output logic             clr_err
);

   localparam int TMR_W = $clog2(CLR_TMO + 1);

   typedef enum logic [1:0] {IDLE, PRESENT, CLEAR} state_t;

   state_t                state, state_nxt;
   logic [4:0]            cwm_q;
   logic [4:0]            pend_q;
   logic [FC_DEPTH_W-1:0] fc_cnt;
   logic [2:0]            last_grant;
   logic [TMR_W-1:0]      timer;

   logic [4:0] rise;
   logic [4:0] clr_mask;
   logic       accept;
   logic       acc_fc;
   logic       fc_nz;
   logic       fc_full;
   logic       cwm_held;
   logic       tmo_hit;
   logic [2:0] grant_id;

   assign rise     = cwm_in & ~cwm_q;
   // The mask is one-hot for ids 0-4. For id 5 it becomes all zero, so the
   // file-card id never touches a counter bit.
   assign clr_mask = 5'b00001 << evt_id;
   assign accept   = (state == PRESENT) && evt_ready;
   assign acc_fc   = accept && (evt_id == 3'd5);
   assign fc_nz    = (fc_cnt != '0);
   assign fc_full  = (fc_cnt == '1);
   assign cwm_held = |(cwm_in & clr_mask);
   assign tmo_hit  = (timer == TMR_W'(CLR_TMO));
   assign pend     = {fc_nz, pend_q};

   // The file-card id has absolute priority. The counters are served
   // round-robin, starting just after the last counter that was granted.
   always_comb begin : grant_sel
      logic [3:0] idx;
      logic [3:0] start;
      logic       found;
      grant_id = 3'd0;
      found    = 1'b0;
      start    = (last_grant >= 3'd4) ? 4'd0 : {1'b0, last_grant} + 4'd1;
      for (int k = 0; k < 5; k++) begin
         idx = start + 4'(k);
         if (idx >= 4'd5) begin
            idx = idx - 4'd5;
         end
         if (!found && pend_q[idx[2:0]]) begin
            grant_id = idx[2:0];
            found    = 1'b1;
         end
      end
      if (fc_nz) begin
         grant_id = 3'd5;
      end
   end

   // Next-state logic and decoded outputs
   always_comb begin
      state_nxt = state;
      evt_valid = 1'b0;
      zz1pb     = 5'b11111;
      case (state)
         IDLE: begin
            if (pend != 6'd0) begin
               state_nxt = PRESENT;
            end
         end
         PRESENT: begin
            evt_valid = 1'b1;
            if (evt_ready) begin
               state_nxt = (evt_id == 3'd5) ? IDLE : CLEAR;
            end
         end
         CLEAR: begin
            zz1pb = ~clr_mask;
            if (!cwm_held || tmo_hit) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sysclk or negedge foo_card_n) begin
      if (!foo_card_n) begin
         state      <= IDLE;
         cwm_q      <= '0;
         pend_q     <= '0;
         fc_cnt     <= '0;
         last_grant <= 3'd4;
         timer      <= '0;
         evt_id     <= 3'd0;
         evt_seq    <= '0;
         evt_ovf    <= 1'b0;
         clr_err    <= 1'b0;
      end else begin
         state  <= state_nxt;
         cwm_q  <= cwm_in;
         // A new edge wins over clearing the accepted event in the same cycle.
         pend_q <= (pend_q & ~(accept ? clr_mask : 5'b00000)) | rise;

         // A pulse that arrives together with an id-5 acceptance cancels it out.
         if (wdfilecard && !acc_fc) begin
            if (fc_full) begin
               evt_ovf <= 1'b1;
            end else begin
               fc_cnt <= fc_cnt + 1'b1;
            end
         end else if (!wdfilecard && acc_fc) begin
            fc_cnt <= fc_cnt - 1'b1;
         end

         if ((state == IDLE) && (pend != 6'd0)) begin
            evt_id <= grant_id;
         end

         if (accept) begin
            evt_seq <= evt_seq + 1'b1;
            if (evt_id != 3'd5) begin
               last_grant <= evt_id;
            end
         end

         if (accept && (evt_id != 3'd5)) begin
            timer <= TMR_W'(1);
         end else if ((state == CLEAR) && (state_nxt == CLEAR)) begin
            timer <= timer + 1'b1;
         end else begin
            timer <= '0;
         end

         if ((state == CLEAR) && cwm_held && tmo_hit) begin
            clr_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cwm_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cwm_event_arbiter
//
// Directed stimulus for cwm_event_arbiter. A behavioural model of the event
// rules is compared against the DUT outputs on every falling edge. Literal
// expectations are checked at key points of each scenario.
// -----------------------------------------------------------------------------
module tb_cwm_event_arbiter;

   localparam int SEQ_W   = 8;
   localparam int CLR_TMO = 15;
   localparam int FC_MAX  = 15;

   logic             sysclk = 1'b0;
   logic             foo_card_n;
   logic [4:0]       cwm_in;
   logic             wdfilecard;
   logic [4:0]       zz1pb;
   logic             evt_valid;
   logic             evt_ready;
   logic [2:0]       evt_id;
   logic [SEQ_W-1:0] evt_seq;
   logic [5:0]       pend;
   logic             evt_ovf;
   logic             clr_err;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 0;

   int acc_ids[$];
   int acc_seqs[$];

   cwm_event_arbiter #(.SEQ_W(SEQ_W), .CLR_TMO(CLR_TMO), .FC_DEPTH_W(4)) dut (
      .sysclk     (sysclk),
      .foo_card_n (foo_card_n),
      .cwm_in     (cwm_in),
      .wdfilecard (wdfilecard),
      .zz1pb      (zz1pb),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_id     (evt_id),
      .evt_seq    (evt_seq),
      .pend       (pend),
      .evt_ovf    (evt_ovf),
      .clr_err    (clr_err)
   );

   always #5 sysclk = ~sysclk;

   // ---------------- behavioural model ----------------
   // m_mode: 0 waiting, 1 offering an event, 2 strobing a clear
   logic [4:0] m_pend, m_q;
   int         m_fc, m_mode, m_id, m_seq, m_last, m_age;
   bit         m_ovf, m_err;

   always @(posedge sysclk or negedge foo_card_n) begin
      if (!foo_card_n) begin
         m_pend = 0; m_q = 0; m_fc = 0; m_mode = 0; m_id = 0;
         m_seq = 0; m_last = 4; m_age = 0; m_ovf = 0; m_err = 0;
      end else begin
         bit         acc, found;
         logic [4:0] op;
         int         ofc, oid, j;
         acc = (m_mode == 1) && evt_ready;
         op  = m_pend;
         ofc = m_fc;
         oid = m_id;
         case (m_mode)
            0: if (op != 0 || ofc > 0) begin
                  if (ofc > 0) m_id = 5;
                  else begin
                     found = 0;
                     for (int k = 1; k <= 5; k++) begin
                        j = (m_last + k) % 5;
                        if (!found && op[j]) begin m_id = j; found = 1; end
                     end
                  end
                  m_mode = 1;
               end
            1: if (evt_ready) begin
                  m_seq = (m_seq + 1) % (1 << SEQ_W);
                  if (oid < 5) begin m_last = oid; m_mode = 2; m_age = 1; end
                  else m_mode = 0;
               end
            default: begin
               if (!cwm_in[oid]) begin m_mode = 0; m_age = 0; end
               else if (m_age == CLR_TMO) begin m_err = 1; m_mode = 0; m_age = 0; end
               else m_age++;
            end
         endcase
         for (int i = 0; i < 5; i++) begin
            if (acc && oid == i) m_pend[i] = 0;
            if (cwm_in[i] && !m_q[i]) m_pend[i] = 1;
         end
         if (wdfilecard && !(acc && oid == 5)) begin
            if (ofc == FC_MAX) m_ovf = 1; else m_fc = ofc + 1;
         end else if (!wdfilecard && acc && oid == 5) m_fc = ofc - 1;
         m_q = cwm_in;
      end
   end

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model
   always @(negedge sysclk) begin
      if (chk_en) begin
         logic [4:0] ezz;
         ezz = (m_mode == 2) ? ~(5'b00001 << m_id) : 5'b11111;
         cmp("m_valid", 32'(evt_valid), 32'(m_mode == 1));
         cmp("m_id",    32'(evt_id),    32'(m_id));
         cmp("m_seq",   32'(evt_seq),   32'(m_seq));
         cmp("m_pend",  32'(pend),      32'({m_fc != 0, m_pend}));
         cmp("m_zz1pb", 32'(zz1pb),     32'(ezz));
         cmp("m_ovf",   32'(evt_ovf),   32'(m_ovf));
         cmp("m_err",   32'(clr_err),   32'(m_err));
         if (foo_card_n && evt_valid && evt_ready) begin
            acc_ids.push_back(int'(evt_id));
            acc_seqs.push_back(int'(evt_seq));
            $display("accept id=%0d seq=%0d t=%0t", evt_id, evt_seq, $time);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic do_reset();
      foo_card_n = 1'b0;
      step(2);
      foo_card_n = 1'b1;
      acc_ids.delete();
      acc_seqs.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int low_cnt;
      foo_card_n = 1'b0; cwm_in = 0; wdfilecard = 0; evt_ready = 1;
      step(2);
      chk_en = 1;
      do_reset();

      // Reset values
      cmp("rst_zz1pb", 32'(zz1pb), 32'h1f);
      cmp("rst_valid", 32'(evt_valid), 0);
      cmp("rst_pend",  32'(pend), 0);
      cmp("rst_seq",   32'(evt_seq), 0);

      // Single counter event, clear released when the flag drops
      cwm_in = 5'b00100;
      step(1); cmp("e2_pend",   32'(pend), 32'h04);
               cmp("e2_nvalid", 32'(evt_valid), 0);
      step(1); cmp("e2_valid",  32'(evt_valid), 1);
               cmp("e2_id",     32'(evt_id), 2);
               cmp("e2_seq",    32'(evt_seq), 0);
      step(1); cmp("e2_clr",    32'(zz1pb), 32'h1b);
      step(2); cmp("e2_clr_h",  32'(zz1pb), 32'h1b);
      cwm_in = 0;
      step(1); cmp("e2_rel",    32'(zz1pb), 32'h1f);
      step(3);

      // Simultaneous events: file-card first, then round-robin from 0
      do_reset();
      cwm_in = 5'b01001; wdfilecard = 1;
      step(1);
      cwm_in = 0; wdfilecard = 0;
      step(14);
      cmp("rr_n", acc_ids.size(), 3);
      if (acc_ids.size() >= 3) begin
         cmp("rr_id0", acc_ids[0], 5); cmp("rr_seq0", acc_seqs[0], 0);
         cmp("rr_id1", acc_ids[1], 0); cmp("rr_seq1", acc_seqs[1], 1);
         cmp("rr_id2", acc_ids[2], 3); cmp("rr_seq2", acc_seqs[2], 2);
      end

      // Backpressure: offer held stable, new edges only update pend
      evt_ready = 0;
      cwm_in = 5'b00010;
      step(5);
      cwm_in = 5'b01010;
      step(17);
      cmp("bp_valid", 32'(evt_valid), 1);
      cmp("bp_id",    32'(evt_id), 1);
      cmp("bp_seq",   32'(evt_seq), 3);
      cmp("bp_pend",  32'(pend), 32'h0a);
      evt_ready = 1; cwm_in = 0;
      step(12);
      cmp("bp_pend0", 32'(pend), 0);
      cmp("bp_n", acc_ids.size(), 5);
      if (acc_ids.size() >= 5) begin
         cmp("bp_id3", acc_ids[3], 1);
         cmp("bp_id4", acc_ids[4], 3);
      end

      // Clear timeout
      do_reset();
      cwm_in = 5'b10000;
      low_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (zz1pb[4] == 1'b0) low_cnt++;
         step(1);
      end
      cmp("tmo_len",   low_cnt, CLR_TMO);
      cmp("tmo_err",   32'(clr_err), 1);
      cmp("tmo_valid", 32'(evt_valid), 0);
      cmp("tmo_pend",  32'(pend), 0);
      cwm_in = 0;
      step(2);

      // File-card saturation, then drain, then sequence wrap
      do_reset();
      evt_ready = 0;
      for (int i = 0; i < 16; i++) begin
         wdfilecard = 1; step(1);
      end
      wdfilecard = 0;
      step(1);
      cmp("fc_ovf",  32'(evt_ovf), 1);
      cmp("fc_pend", 32'(pend), 32'h20);
      cmp("fc_id",   32'(evt_id), 5);
      evt_ready = 1;
      for (int i = 0; i < 80; i++) begin
         if (pend == 0) break;
         step(1);
      end
      step(2);
      cmp("fc_drain", 32'(pend), 0);
      cmp("fc_seq15", 32'(evt_seq), 15);
      for (int i = 0; i < 241; i++) begin
         wdfilecard = 1; step(1);
         wdfilecard = 0; step(3);
      end
      step(4);
      cmp("wrap_seq", 32'(evt_seq), 0);
      cmp("wrap_n",   acc_ids.size(), 256);
      if (acc_seqs.size() == 256) cmp("wrap_last", acc_seqs[255], 255);

      // Reset during a clear
      do_reset();
      cwm_in = 5'b00010;
      step(4);
      cmp("rc_clr", 32'(zz1pb), 32'h1d);
      #2 foo_card_n = 1'b0;
      #1;
      cmp("rc_zz",    32'(zz1pb), 32'h1f);
      cmp("rc_valid", 32'(evt_valid), 0);
      cmp("rc_seq",   32'(evt_seq), 0);
      cmp("rc_pend",  32'(pend), 0);
      step(1);
      foo_card_n = 1'b1;
      step(1);
      cmp("rc_edge",  32'(pend), 32'h02);
      step(1);
      cmp("rc_valid2", 32'(evt_valid), 1);
      cmp("rc_id",     32'(evt_id), 1);
      cwm_in = 0;
      step(5);

      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
